selection_of_avatar_p: RTL and testbench

SELECTION_OF_AVATAR_P -- requirements
Module: selection_of_avatar_p

---
 rtl/selection_of_avatar_p.sv | 133 +++++++++++++
 tb/tb_selection_of_avatar_p.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/selection_of_avatar_p.sv
// selection_of_avatar_p: timed register/vote/tally election FSM; define ELECTION_TIE_DETECT_EN to add the Tie output
module selection_of_avatar_p #(
  parameter int ID_W        = 6,
  parameter int CAND_W      = 2,
  parameter int CNT_W       = 6,
  parameter int BOX_W       = 2,
  parameter int REG_CYCLES  = 100,
  parameter int VOTE_CYCLES = 100
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              valid,
  input  logic [1:0]        mode,
  input  logic [ID_W-1:0]   userID,
  input  logic [CAND_W-1:0] candidate,
  output logic [BOX_W-1:0]  ballotBoxId,
  output logic [1:0]        phase,
  output logic [ID_W:0]     numberOfRegisteredVoters,
  output logic [CNT_W-1:0]  numberOfVotesWinner,
  output logic [CAND_W-1:0] WinnerId,
  output logic              WinnerValid,
  output logic              AlreadyRegistered,
  output logic              AlreadyVoted,
  output logic              NotRegistered,
  output logic              VotingHasNotStarted,
`ifdef ELECTION_TIE_DETECT_EN
  output logic              Tie,
`endif
  output logic              RegistrationHasEnded
);
  typedef enum logic [1:0] {REGISTER, VOTE, TALLY, DONE} phase_t;
  phase_t            st;
  logic [31:0]       cyc;
  logic [2**ID_W-1:0] reg_m, voted_m;
  logic [CNT_W-1:0]  votes [2**CAND_W];
  logic [CAND_W-1:0] best_id, nb_id, t_idx;
  logic [CNT_W-1:0]  best_cnt, nb_cnt;
  logic              take;
`ifdef ELECTION_TIE_DETECT_EN
  logic              best_tie, nb_tie;
`endif
  assign phase = st;
  assign t_idx = cyc[CAND_W-1:0];
  // running maximum for the candidate examined this tally edge; first candidate seeds it, ties keep the lower index
  always_comb begin
    take   = (t_idx == '0) || (votes[t_idx] > best_cnt);
    nb_id  = take ? t_idx : best_id;
    nb_cnt = take ? votes[t_idx] : best_cnt;
`ifdef ELECTION_TIE_DETECT_EN
    nb_tie = take ? 1'b0 : ((votes[t_idx] == best_cnt) ? 1'b1 : best_tie);
`endif
  end
  // phase sequencing, request handling, tally and registered result/status outputs
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      st                       <= REGISTER;
      cyc                      <= '0;
      reg_m                    <= '0;
      voted_m                  <= '0;
      for (int i = 0; i < 2**CAND_W; i++) votes[i] <= '0;
      best_id                  <= '0;
      best_cnt                 <= '0;
      ballotBoxId              <= '0;
      numberOfRegisteredVoters <= '0;
      numberOfVotesWinner      <= '0;
      WinnerId                 <= '0;
      WinnerValid              <= 1'b0;
      AlreadyRegistered        <= 1'b0;
      AlreadyVoted             <= 1'b0;
      NotRegistered            <= 1'b0;
      VotingHasNotStarted      <= 1'b0;
      RegistrationHasEnded     <= 1'b0;
`ifdef ELECTION_TIE_DETECT_EN
      best_tie                 <= 1'b0;
      Tie                      <= 1'b0;
`endif
    end else begin
      AlreadyRegistered    <= 1'b0;
      AlreadyVoted         <= 1'b0;
      NotRegistered        <= 1'b0;
      VotingHasNotStarted  <= 1'b0;
      RegistrationHasEnded <= 1'b0;
      case (st)
        REGISTER: begin
          cyc <= (cyc == REG_CYCLES - 1) ? '0 : cyc + 1;
          if (cyc == REG_CYCLES - 1) st <= VOTE;
        end
        VOTE: begin
          cyc <= (cyc == VOTE_CYCLES - 1) ? '0 : cyc + 1;
          if (cyc == VOTE_CYCLES - 1) st <= TALLY;
        end
        TALLY: begin
          cyc      <= cyc + 1;
          best_id  <= nb_id;
          best_cnt <= nb_cnt;
`ifdef ELECTION_TIE_DETECT_EN
          best_tie <= nb_tie;
`endif
          if (cyc == 2**CAND_W - 1) begin
            st                  <= DONE;
            WinnerId            <= nb_id;
            numberOfVotesWinner <= nb_cnt;
            WinnerValid         <= 1'b1;
`ifdef ELECTION_TIE_DETECT_EN
            Tie                 <= nb_tie;
`endif
          end
        end
        default: ;
      endcase
      if (valid) begin
        ballotBoxId <= userID[ID_W-1 -: BOX_W];
        if (st == REGISTER && mode == 2'd0) begin
          if (reg_m[userID]) AlreadyRegistered <= 1'b1;
          else begin
            reg_m[userID]            <= 1'b1;
            numberOfRegisteredVoters <= numberOfRegisteredVoters + 1'b1;
          end
        end
        if (st == REGISTER && mode == 2'd1) VotingHasNotStarted <= 1'b1;
        if (st == VOTE && mode == 2'd0) RegistrationHasEnded <= 1'b1;
        if (st == VOTE && mode == 2'd1) begin
          if (!reg_m[userID]) NotRegistered <= 1'b1;
          else if (voted_m[userID]) AlreadyVoted <= 1'b1;
          else begin
            voted_m[userID]   <= 1'b1;
            votes[candidate]  <= (votes[candidate] == '1) ? votes[candidate] : votes[candidate] + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_selection_of_avatar_p.sv
// tb_selection_of_avatar_p: table, directed and random checks of the election FSM against a behavioural model
module tb_selection_of_avatar_p;
  localparam int R = 24, V = 24, NC = 4, SAT = 3;
  logic CLK = 0, RST_N = 0, valid = 0;
  logic [1:0] mode = 0;
  logic [5:0] userID = 0;
  logic [1:0] candidate = 0;
  logic [1:0] ballotBoxId, phase, WinnerId, numberOfVotesWinner;
  logic [6:0] numberOfRegisteredVoters;
  logic WinnerValid, AlreadyRegistered, AlreadyVoted, NotRegistered, VotingHasNotStarted, RegistrationHasEnded;
`ifdef ELECTION_TIE_DETECT_EN
  logic Tie;
`endif
  selection_of_avatar_p #(.ID_W(6), .CAND_W(2), .CNT_W(2), .BOX_W(2), .REG_CYCLES(R), .VOTE_CYCLES(V)) dut (
    .CLK(CLK), .RST_N(RST_N), .valid(valid), .mode(mode), .userID(userID), .candidate(candidate),
    .ballotBoxId(ballotBoxId), .phase(phase), .numberOfRegisteredVoters(numberOfRegisteredVoters),
    .numberOfVotesWinner(numberOfVotesWinner), .WinnerId(WinnerId), .WinnerValid(WinnerValid),
    .AlreadyRegistered(AlreadyRegistered), .AlreadyVoted(AlreadyVoted), .NotRegistered(NotRegistered),
    .VotingHasNotStarted(VotingHasNotStarted),
`ifdef ELECTION_TIE_DETECT_EN
    .Tie(Tie),
`endif
    .RegistrationHasEnded(RegistrationHasEnded));
  always #5 CLK = ~CLK;
  int errors = 0, checks = 0;
  int e, mnreg, mbox, mflags, mwid, mwcnt, mwv, mtie;
  bit mreg [64];
  bit mvoted [64];
  int mvotes [NC];
  function automatic int phase_of(int n);
    return n < R ? 0 : n < R + V ? 1 : n < R + V + NC ? 2 : 3;
  endfunction
  function automatic logic [4:0] dut_flags();
    return {AlreadyRegistered, AlreadyVoted, NotRegistered, VotingHasNotStarted, RegistrationHasEnded};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, e);
    end
  endtask
  task automatic chk_all();
    chk("phase", 32'(phase), mnreg >= 0 ? 32'(phase_of(e)) : 0);
    chk("nreg", 32'(numberOfRegisteredVoters), mnreg);
    chk("box", 32'(ballotBoxId), mbox);
    chk("flags", 32'(dut_flags()), mflags);
    chk("win_id", 32'(WinnerId), mwid);
    chk("win_cnt", 32'(numberOfVotesWinner), mwcnt);
    chk("win_valid", 32'(WinnerValid), mwv);
`ifdef ELECTION_TIE_DETECT_EN
    chk("tie", 32'(Tie), mtie);
`endif
  endtask
  task automatic model_edge(input bit v, input int m, input int id, input int c);
    int ph, best, nmax;
    ph = phase_of(e);
    mflags = 0;
    if (v) begin
      mbox = id / 16;
      if (ph == 0 && m == 0) begin
        if (mreg[id]) mflags = 16;
        else begin mreg[id] = 1; mnreg++; end
      end else if (ph == 0 && m == 1) mflags = 2;
      else if (ph == 1 && m == 0) mflags = 1;
      else if (ph == 1 && m == 1) begin
        if (!mreg[id]) mflags = 4;
        else if (mvoted[id]) mflags = 8;
        else begin mvoted[id] = 1; if (mvotes[c] < SAT) mvotes[c]++; end
      end
    end
    e++;
    if (phase_of(e) == 3 && mwv == 0) begin
      best = 0;
      for (int i = 1; i < NC; i++) if (mvotes[i] > mvotes[best]) best = i;
      nmax = 0;
      for (int i = 0; i < NC; i++) if (mvotes[i] == mvotes[best]) nmax++;
      mwid = best; mwcnt = mvotes[best]; mwv = 1; mtie = nmax >= 2;
    end
  endtask
  task automatic step(input bit v, input int m, input int id, input int c);
    valid = v; mode = 2'(m); userID = 6'(id); candidate = 2'(c);
    @(posedge CLK);
    model_edge(v, m, id, c);
    #1;
    chk_all();
  endtask
  task automatic do_reset();
    RST_N = 0; valid = 1; mode = 0; userID = 6'($urandom_range(0, 63));
    @(posedge CLK);
    e = 0; mnreg = 0; mbox = 0; mflags = 0; mwid = 0; mwcnt = 0; mwv = 0; mtie = 0;
    for (int i = 0; i < 64; i++) begin mreg[i] = 0; mvoted[i] = 0; end
    for (int i = 0; i < NC; i++) mvotes[i] = 0;
    #1;
    chk_all();
    RST_N = 1; valid = 0;
  endtask
  task automatic idle_to(input int p);
    while (phase_of(e) != p) step(0, 0, 0, 0);
  endtask
  typedef struct {int ph; bit v; int m; int id; int c; int flags; int nreg;} vec_t;
  vec_t tbl [11];
  initial begin
    tbl[0]  = '{0, 1, 0, 5, 0, 0, 1};
    tbl[1]  = '{0, 1, 0, 5, 0, 16, 1};
    tbl[2]  = '{0, 1, 1, 5, 0, 2, 1};
    tbl[3]  = '{0, 1, 0, 1, 0, 0, 2};
    tbl[4]  = '{0, 1, 0, 2, 0, 0, 3};
    tbl[5]  = '{0, 1, 2, 3, 0, 0, 3};
    tbl[6]  = '{1, 1, 0, 7, 0, 1, 3};
    tbl[7]  = '{1, 1, 1, 1, 2, 0, 3};
    tbl[8]  = '{1, 1, 1, 1, 2, 8, 3};
    tbl[9]  = '{1, 1, 1, 9, 1, 4, 3};
    tbl[10] = '{1, 1, 3, 2, 0, 0, 3};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      idle_to(tbl[i].ph);
      step(tbl[i].v, tbl[i].m, tbl[i].id, tbl[i].c);
      chk($sformatf("tbl%0d_flags", i), 32'(dut_flags()), tbl[i].flags);
      chk($sformatf("tbl%0d_nreg", i), 32'(numberOfRegisteredVoters), tbl[i].nreg);
    end
    idle_to(2);
    chk("tally_no_result", 32'(WinnerValid), 0);
    idle_to(3);
    chk("tbl_win_id", 32'(WinnerId), 2);
    chk("tbl_win_cnt", 32'(numberOfVotesWinner), 1);
    chk("tbl_win_valid", 32'(WinnerValid), 1);
    step(1, 0, 40, 0);
    chk("done_ignored_flags", 32'(dut_flags()), 0);
    chk("done_box", 32'(ballotBoxId), 2);
    // tie between candidates 1 and 3
    do_reset();
    for (int i = 30; i < 34; i++) step(1, 0, i, 0);
    idle_to(1);
    step(1, 1, 30, 1); step(1, 1, 31, 1); step(1, 1, 32, 3); step(1, 1, 33, 3);
    idle_to(3);
    chk("tie_win_id", 32'(WinnerId), 1);
    chk("tie_win_cnt", 32'(numberOfVotesWinner), 2);
`ifdef ELECTION_TIE_DETECT_EN
    chk("tie_flag", 32'(Tie), 1);
`endif
    // reset mid-vote discards everything
    do_reset();
    for (int i = 10; i < 13; i++) step(1, 0, i, 0);
    idle_to(1);
    step(1, 1, 10, 0); step(1, 1, 11, 1); step(1, 1, 12, 1);
    do_reset();
    chk("rst_phase", 32'(phase), 0);
    chk("rst_nreg", 32'(numberOfRegisteredVoters), 0);
    step(1, 0, 10, 0);
    chk("rereg_no_already", 32'(AlreadyRegistered), 0);
    chk("rereg_nreg", 32'(numberOfRegisteredVoters), 1);
    chk("reg_len_still_register", 32'(phase), 0);
    // saturation and DONE timing
    do_reset();
    for (int i = 20; i < 25; i++) step(1, 0, i, 0);
    idle_to(1);
    for (int i = 20; i < 25; i++) step(1, 1, i, 0);
    while (e < R + V + NC - 1) step(0, 0, 0, 0);
    chk("pre_done_valid", 32'(WinnerValid), 0);
    chk("pre_done_phase", 32'(phase), 2);
    step(0, 0, 0, 0);
    chk("done_edge_count", e, R + V + 4);
    chk("done_phase", 32'(phase), 3);
    chk("sat_win_valid", 32'(WinnerValid), 1);
    chk("sat_win_cnt", 32'(numberOfVotesWinner), 3);
    chk("sat_win_id", 32'(WinnerId), 0);
    // all-zero election
    do_reset();
    idle_to(3);
    chk("zero_win_id", 32'(WinnerId), 0);
    chk("zero_win_cnt", 32'(numberOfVotesWinner), 0);
`ifdef ELECTION_TIE_DETECT_EN
    chk("zero_tie", 32'(Tie), 1);
`endif
    // random rounds against the model
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < R + V + NC + 6; i++)
        step(1'($urandom_range(0, 1)), $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 15), $urandom_range(0, 3));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
